// File: rtl/fifo_word_reader_pkg.sv
// Shared types and constants for the 16-in/24-out packing FIFO and its read-side controller.
package fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SETTLE,
    CHECK,
    LOAD,
    HOLD
  } rd_state_t;

  localparam int unsigned FIFO_RD_W = 24;
  localparam int unsigned FIFO_WR_W = 16;

  // Watermark defaults, shared with the FIFO write side.
  localparam int unsigned FIFO_HW_DEFAULT = 384;
  localparam int unsigned FIFO_LW_DEFAULT = 128;

endpackage

// File: rtl/fifo_word_reader_if.sv
// Downstream valid/ready word interface; the reader drives through the master modport.
interface fifo_word_reader_if #(
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fifo_word_reader_rd_delay_counter.sv
// Loadable down-counter used for the settle and prime waits.
// EARLY=1 flags done while the final count is in progress (count <= 1) rather than at zero.
module rd_delay_counter #(
  parameter int unsigned W     = 8,
  parameter bit          EARLY = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign done = EARLY ? (cnt[W-1:1] == '0) : (cnt == '0);
endmodule

// File: rtl/fifo_word_reader.sv
// Read-side controller: drains the packing FIFO into a valid/ready stream with watermark hysteresis.
// Optional FIFO_READER_UNDERRUN_CNT_EN adds a saturating underrun counter with synchronous clear.
module fifo_word_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = FIFO_RD_W,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned PRIME_WAIT = 0
) (
  input  logic              clk143,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_hw,
  input  logic              fifo_lw,
  output logic              pop_front,
  output logic              running,
`ifdef FIFO_READER_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
  input  logic              underrun_clr,
`endif
  fifo_word_reader_if.master dn
);
  localparam int unsigned CNT_W = 8;

  rd_state_t         state, state_n;
  logic              pop_q, pop_n;
  logic              valid_q, valid_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              running_q, running_n;
  logic              settle_load, settle_dec, settle_done;
  logic              prime_load, prime_dec, prime_done;

  rd_delay_counter #(.W(CNT_W), .EARLY(1'b1)) u_settle (
    .clk      (clk143),
    .rst_n    (reset_n),
    .load     (settle_load),
    .load_val (CNT_W'(SETTLE_CYC)),
    .dec      (settle_dec),
    .done     (settle_done)
  );

  rd_delay_counter #(.W(CNT_W), .EARLY(1'b0)) u_prime (
    .clk      (clk143),
    .rst_n    (reset_n),
    .load     (prime_load),
    .load_val (CNT_W'(PRIME_WAIT)),
    .dec      (prime_dec),
    .done     (prime_done)
  );

  always_ff @(posedge clk143 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pop_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      running_q <= 1'b0;
    end else begin
      state     <= state_n;
      pop_q     <= pop_n;
      valid_q   <= valid_n;
      data_q    <= data_n;
      running_q <= running_n;
    end
  end

  // Registered outputs are computed one cycle ahead, so the capture/pop happens on the CHECK->LOAD edge.
  always_comb begin
    state_n     = state;
    pop_n       = 1'b0;
    valid_n     = valid_q;
    data_n      = data_q;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    prime_load  = 1'b0;
    prime_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && fifo_hw) begin
          state_n    = PRIME;
          prime_load = 1'b1;
        end
      end
      PRIME: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (prime_done) begin
          state_n     = SETTLE;
          settle_load = 1'b1;
        end else begin
          prime_dec = 1'b1;
        end
      end
      SETTLE: begin
        settle_dec = 1'b1;
        if (settle_done) state_n = CHECK;
      end
      CHECK: begin
        if (fifo_lw || !enable) begin
          state_n = IDLE;
        end else begin
          state_n = LOAD;
          pop_n   = 1'b1;
          valid_n = 1'b1;
          data_n  = fifo_dout;
        end
      end
      LOAD: begin
        // out_valid is already high in LOAD, so an accept here skips HOLD.
        if (dn.out_ready) begin
          state_n     = SETTLE;
          valid_n     = 1'b0;
          settle_load = 1'b1;
        end else begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && dn.out_ready) begin
          state_n     = SETTLE;
          valid_n     = 1'b0;
          settle_load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    running_n = (state_n != IDLE) && (state_n != PRIME);
  end

  assign pop_front    = pop_q;
  assign running      = running_q;
  assign dn.out_data  = data_q;
  assign dn.out_valid = valid_q;

`ifdef FIFO_READER_UNDERRUN_CNT_EN
  logic underrun_evt;
  assign underrun_evt = (state == CHECK) && fifo_lw && enable;

  always_ff @(posedge clk143 or negedge reset_n) begin
    if (!reset_n)
      underrun_cnt <= '0;
    else if (underrun_clr)
      underrun_cnt <= '0;
    else if (underrun_evt && (underrun_cnt != 16'hFFFF))
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed self-checking bench for fifo_word_reader with a 2-cycle-latency FIFO head model.
module tb_fifo_word_reader;
  import fifo_pkg::*;

  localparam int unsigned DW = 24;

  logic          clk143 = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_hw = 1'b0;
  logic          fifo_lw = 1'b0;
  logic [DW-1:0] fifo_dout;
  logic          pop_front;
  logic          running;
`ifdef FIFO_READER_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
  logic          underrun_clr = 1'b0;
`endif

  fifo_word_reader_if #(.DATA_W(DW)) dn_if ();

  fifo_word_reader #(.DATA_W(DW), .SETTLE_CYC(2), .PRIME_WAIT(0)) dut (
    .clk143       (clk143),
    .reset_n      (reset_n),
    .enable       (enable),
    .fifo_dout    (fifo_dout),
    .fifo_hw      (fifo_hw),
    .fifo_lw      (fifo_lw),
    .pop_front    (pop_front),
    .running      (running),
`ifdef FIFO_READER_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
    .underrun_clr (underrun_clr),
`endif
    .dn           (dn_if)
  );

  always #5 clk143 = ~clk143;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned pop_cnt = 0;
  int unsigned viol = 0;

  // FIFO head model: pointer moves the edge after a pop, dout is a registered read of the pointer.
  logic [DW-1:0] mem [16];
  logic [3:0]    fptr;
  logic          model_rst = 1'b1;

  always @(posedge clk143) begin
    if (model_rst) begin
      fptr      <= '0;
      fifo_dout <= '0;
    end else begin
      if (pop_front) fptr <= fptr + 4'd1;
      fifo_dout <= mem[fptr];
    end
  end

  logic prev_pop = 1'b0;
  logic prev_pend = 1'b0;
  always @(negedge clk143) begin
    if (pop_front) begin
      pop_cnt++;
      if (prev_pop || prev_pend) viol++;
    end
    prev_pop  = pop_front;
    prev_pend = dn_if.out_valid && !dn_if.out_ready;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk143);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 24'hA1B2C3;
    for (int i = 1; i <= 8; i++) mem[i] = DW'(i);
    mem[9]  = 24'h5A5A5A;
    mem[10] = 24'hC0FFEE;
    dn_if.out_ready = 1'b0;

    repeat (3) tick();
    check_eq("rst_valid", 32'(dn_if.out_valid), 32'd0);
    check_eq("rst_pop", 32'(pop_front), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_data", 32'(dn_if.out_data), 32'd0);

    reset_n   = 1'b1;
    model_rst = 1'b0;
    fifo_hw   = 1'b1;
    repeat (3) tick();
    check_eq("no_enable_idle", 32'(running), 32'd0);
    check_eq("no_enable_pops", pop_cnt, 32'd0);

    // Prime start: PRIME, SETTLE x2, CHECK, then LOAD.
    enable = 1'b1;
    tick();
    check_eq("prime_running", 32'(running), 32'd0);
    tick();
    check_eq("settle_running", 32'(running), 32'd1);
    tick();
    tick();
    check_eq("check_pop", 32'(pop_front), 32'd0);
    tick();
    check_eq("load_pop", 32'(pop_front), 32'd1);
    check_eq("load_valid", 32'(dn_if.out_valid), 32'd1);
    check_eq("load_data", 32'(dn_if.out_data), 32'hA1B2C3);
    fifo_hw = 1'b0;

    // Backpressure.
    repeat (20) tick();
    check_eq("bp_data", 32'(dn_if.out_data), 32'hA1B2C3);
    check_eq("bp_valid", 32'(dn_if.out_valid), 32'd1);
    check_eq("bp_pops", pop_cnt, 32'd1);
    dn_if.out_ready = 1'b1;
    tick();
    check_eq("bp_accept_valid", 32'(dn_if.out_valid), 32'd0);
    tick();
    tick();
    check_eq("bp_gap_pop", 32'(pop_front), 32'd0);
    tick();
    check_eq("bp_next_pop", 32'(pop_front), 32'd1);
    check_eq("bp_next_data", 32'(dn_if.out_data), 32'd1);

    // Streaming at one word per 4 cycles.
    for (int k = 2; k <= 8; k++) begin
      repeat (4) tick();
      check_eq($sformatf("stream_pop_%0d", k), 32'(pop_front), 32'd1);
      check_eq($sformatf("stream_data_%0d", k), 32'(dn_if.out_data), 32'(k));
    end

    // Underrun guard.
    fifo_lw = 1'b1;
    repeat (3) tick();
    check_eq("ur_check_running", 32'(running), 32'd1);
    tick();
    check_eq("ur_idle_running", 32'(running), 32'd0);
    repeat (5) tick();
    check_eq("ur_pops", pop_cnt, 32'd9);
`ifdef FIFO_READER_UNDERRUN_CNT_EN
    check_eq("ur_cnt_1", 32'(underrun_cnt), 32'd1);
`endif

    // Both watermarks high: hw starts priming, lw then blocks the pop.
    fifo_hw = 1'b1;
    repeat (5) tick();
    check_eq("both_running", 32'(running), 32'd0);
    check_eq("both_pops", pop_cnt, 32'd9);
    fifo_hw = 1'b0;
    fifo_lw = 1'b0;
`ifdef FIFO_READER_UNDERRUN_CNT_EN
    check_eq("ur_cnt_2", 32'(underrun_cnt), 32'd2);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check_eq("ur_cnt_clr", 32'(underrun_cnt), 32'd0);
`endif

    // Enable drop during HOLD.
    dn_if.out_ready = 1'b0;
    fifo_hw = 1'b1;
    repeat (5) tick();
    check_eq("en_load_data", 32'(dn_if.out_data), 32'h5A5A5A);
    fifo_hw = 1'b0;
    tick();
    enable = 1'b0;
    repeat (3) tick();
    check_eq("en_hold_valid", 32'(dn_if.out_valid), 32'd1);
    check_eq("en_hold_data", 32'(dn_if.out_data), 32'h5A5A5A);
    dn_if.out_ready = 1'b1;
    tick();
    dn_if.out_ready = 1'b0;
    check_eq("en_accept_valid", 32'(dn_if.out_valid), 32'd0);
    repeat (3) tick();
    check_eq("en_idle_running", 32'(running), 32'd0);
    repeat (4) tick();
    check_eq("en_pops", pop_cnt, 32'd10);

    // Asynchronous reset while holding a word.
    enable  = 1'b1;
    fifo_hw = 1'b1;
    repeat (5) tick();
    check_eq("rh_load_data", 32'(dn_if.out_data), 32'hC0FFEE);
    fifo_hw = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rh_valid", 32'(dn_if.out_valid), 32'd0);
    check_eq("rh_pop", 32'(pop_front), 32'd0);
    check_eq("rh_running", 32'(running), 32'd0);
    check_eq("rh_data", 32'(dn_if.out_data), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check_eq("rh_after_pops", pop_cnt, 32'd11);
    check_eq("rh_after_running", 32'(running), 32'd0);

    check_eq("pop_spacing", viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
